// File: rtl/matrix_a_stream_port.sv
// matrix_a_stream_port
//   Streaming front end for the matrix-A row/column-pair store (8 rows x 4
//   cols). Two rows travel together as one row pair on the store bus.
//   Load: row-major elements arrive on s_*. Each group of 8 is packed into
//   one row-pair write.
//   Dump: each row pair is read, captured, and replayed row-major on m_*.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start_load, start_dump     start pulses (sampled only in IDLE, load wins)
//   busy, done                 busy outside IDLE, one-cycle done pulse
//   s_valid/s_ready/s_data     element input stream
//   m_valid/m_ready/m_data     element output stream
//   m_last                     marks element 31 of a dump
//   mem_we/mem_addr            store command (row mode, row-pair address)
//   mem_wdata/mem_rdata        store data buses. The low half carries the even
//                              row and the high half carries the odd row.

module matrix_a_stream_port #(
    parameter int data_width        = 24,
    parameter int no_of_row         = 3,
    parameter int no_of_col         = 2,
    parameter int max_no_of_row_col = 3,
    parameter int addr_width        = 6
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start_load,
    input  logic                                          start_dump,
    output logic                                          busy,
    output logic                                          done,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [data_width-1:0]                         s_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [data_width-1:0]                         m_data,
    output logic                                          m_last,
    output logic                                          mem_we,
    output logic [addr_width-1:0]                         mem_addr,
    output logic [2*data_width*(2**max_no_of_row_col)-1:0] mem_wdata,
    input  logic [2*data_width*(2**max_no_of_row_col)-1:0] mem_rdata
);

    localparam int LANES  = 2**max_no_of_row_col;
    localparam int HALF_W = data_width * LANES;
    localparam int BUS_W  = 2 * HALF_W;
    localparam int COLS   = 2**no_of_col;
    localparam int SLOTS  = 2 * COLS;
    localparam int K_W    = no_of_col + 1;
    localparam int P_W    = no_of_row - 1;

    localparam logic [K_W-1:0] K_ONE  = K_W'(1);
    localparam logic [K_W-1:0] K_LAST = K_W'(SLOTS - 1);
    localparam logic [P_W-1:0] P_ONE  = P_W'(1);
    localparam logic [P_W-1:0] P_LAST = {P_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LD_COLLECT,
        LD_WRITE,
        DP_READ,
        DP_CAPTURE,
        DP_STREAM,
        DONE
    } state_t;

    state_t                state;
    logic [P_W-1:0]        p;
    logic [K_W-1:0]        k;
    logic [data_width-1:0] buffer [SLOTS];
    logic [BUS_W-1:0]      packed_wdata;
    logic                  unused_rdata;

    // Slot k maps to row 2p + k/COLS and col k%COLS.
    // Slots 0..COLS-1 fill the low half and the remaining slots fill the high half.
    // The unused upper lanes of each half stay zero.
    always_comb begin
        packed_wdata = '0;
        for (int c = 0; c < COLS; c++) begin
            packed_wdata[c*data_width +: data_width]          = buffer[c];
            packed_wdata[HALF_W + c*data_width +: data_width] = buffer[COLS+c];
        end
    end

    // The store reports every lane, but only lanes 0..COLS-1 of each half hold matrix data.
    assign unused_rdata = ^{mem_rdata[HALF_W-1:COLS*data_width],
                            mem_rdata[BUS_W-1:HALF_W+COLS*data_width]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            k     <= '0;
            for (int i = 0; i < SLOTS; i++) buffer[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state <= LD_COLLECT;
                        p     <= '0;
                        k     <= '0;
                    end else if (start_dump) begin
                        state <= DP_READ;
                        p     <= '0;
                        k     <= '0;
                    end
                end
                LD_COLLECT: begin
                    if (s_valid) begin
                        buffer[k] <= s_data;
                        k         <= k + K_ONE;
                        if (k == K_LAST) state <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    if (p == P_LAST) begin
                        state <= DONE;
                    end else begin
                        p     <= p + P_ONE;
                        k     <= '0;
                        state <= LD_COLLECT;
                    end
                end
                // The store registers its read data on the edge that closes this state.
                DP_READ: state <= DP_CAPTURE;
                DP_CAPTURE: begin
                    for (int c = 0; c < COLS; c++) begin
                        buffer[c]      <= mem_rdata[c*data_width +: data_width];
                        buffer[COLS+c] <= mem_rdata[HALF_W + c*data_width +: data_width];
                    end
                    k     <= '0;
                    state <= DP_STREAM;
                end
                DP_STREAM: begin
                    if (m_ready) begin
                        k <= k + K_ONE;
                        if (k == K_LAST) begin
                            if (p == P_LAST) begin
                                state <= DONE;
                            end else begin
                                p     <= p + P_ONE;
                                state <= DP_READ;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs are decoded from registered state. During a stall, k and
    // the buffer cannot change, so m_data and m_last stay stable.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign s_ready   = (state == LD_COLLECT);
    assign m_valid   = (state == DP_STREAM);
    assign m_data    = m_valid ? buffer[k] : '0;
    assign m_last    = m_valid && (p == P_LAST) && (k == K_LAST);
    assign mem_we    = (state == LD_WRITE);
    // Row-mode address of the even row of pair p: {1, 2p, col 0}.
    assign mem_addr  = busy ? {1'b1, p, 1'b0, {no_of_col{1'b0}}} : '0;
    assign mem_wdata = mem_we ? packed_wdata : '0;

endmodule
